// File: rtl/video_fill_pkg.sv
// Shared types and constants for the rectangle-fill engine and its bus arbiter.
// Latency: n/a (types, constants and a constant-stride shift-add helper only).
// Backpressure: n/a.
package video_fill_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } fill_state_t;

  localparam int unsigned H_MAX_DEF = 640;
  localparam int unsigned V_MAX_DEF = 480;

  localparam logic [1:0] REG_ORG   = 2'd0;
  localparam logic [1:0] REG_SIZE  = 2'd1;
  localparam logic [1:0] REG_COLOR = 2'd2;
  localparam logic [1:0] REG_CMD   = 2'd3;

  localparam int CMD_START_BIT = 0;
  localparam int CMD_ABORT_BIT = 1;

  // y * stride built from shifted copies of y, one per set bit of the
  // constant stride, so no multiplier is inferred.
  function automatic logic [19:0] stride_mul(input logic [9:0] y, input logic [19:0] stride);
    logic [19:0] acc;
    acc = '0;
    for (int i = 0; i < 20; i++) begin
      if (stride[i]) acc = acc + (20'(y) << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/fill_addr_gen.sv
// Column/row walker for the fill engine; yields the 20-bit frame address of the current pixel.
// Latency: addr/last are combinational from the counters; counters move one step per edge.
// Backpressure: stall (CPU owns the bus) freezes col, row and row_base.
module fill_addr_gen
  import video_fill_pkg::*;
#(
  parameter int unsigned H_MAX = H_MAX_DEF
) (
  input  logic        clk_sys,
  input  logic        reset_sys,
  input  logic        load,
  input  logic        advance,
  input  logic        stall,
  input  logic [9:0]  x0,
  input  logic [9:0]  y0,
  input  logic [10:0] w,
  input  logic [10:0] h,
  output logic [19:0] addr,
  output logic        last
);

  logic [10:0] col;
  logic [10:0] row;
  logic [19:0] row_base;
  logic        col_last;

  assign col_last = (col == w - 11'd1);
  assign last     = col_last && (row == h - 11'd1);
  // Address wraps at 20 bits when the rectangle runs off the frame.
  assign addr     = row_base + 20'(x0) + 20'(col);

  // Counters: reload at setup, step on each granted pixel, wrap col at row end.
  always_ff @(posedge clk_sys or negedge reset_sys) begin
    if (!reset_sys) begin
      col      <= '0;
      row      <= '0;
      row_base <= '0;
    end else if (load) begin
      col      <= '0;
      row      <= '0;
      row_base <= stride_mul(y0, 20'(H_MAX));
    end else if (advance && !stall) begin
      if (col_last) begin
        col      <= '0;
        row      <= row + 11'd1;
        row_base <= row_base + 20'(H_MAX);
      end else begin
        col      <= col + 11'd1;
      end
    end
  end

endmodule

// File: rtl/video_fill_arbiter.sv
// Rectangle-fill engine sharing the video write port with the CPU (CPU always wins); FILL_CLIP_EN clips to the frame.
// Latency: CPU -> video_* 1 cycle; start -> first fill write 2 cycles; w*h fill done in w*h+2 cycles on an idle bus.
// Backpressure: any cpu_cs cycle stalls the engine with counters held; CPU traffic is never delayed or dropped.
module video_fill_arbiter
  import video_fill_pkg::*;
#(
  parameter int unsigned H_MAX = H_MAX_DEF,
  parameter int unsigned V_MAX = V_MAX_DEF,
  parameter int unsigned DW    = 9
) (
  input  logic        clk_sys,
  input  logic        reset_sys,
  input  logic        cpu_cs,
  input  logic        cpu_wr,
  input  logic [20:0] cpu_addr,
  input  logic [31:0] cpu_wr_data,
  input  logic        ctrl_cs,
  input  logic        ctrl_wr,
  input  logic [1:0]  ctrl_addr,
  input  logic [31:0] ctrl_wr_data,
  output logic [31:0] ctrl_rd_data,
  output logic        video_cs,
  output logic        video_wr,
  output logic [20:0] video_addr,
  output logic [31:0] video_wr_data,
  output logic        fill_busy,
  output logic        fill_done
);

  fill_state_t state, state_nxt;

  logic [9:0]    reg_x0, reg_y0;
  logic [10:0]   reg_w, reg_h;
  logic [DW-1:0] reg_colour;

  logic [9:0]    lat_x0, lat_y0;
  logic [10:0]   lat_w, lat_h;
  logic [DW-1:0] lat_colour;

  logic [10:0]   clip_w, clip_h;
  logic          cmd_wr, start_cmd, abort_cmd;
  logic          start_acc, load, eng_adv, set_done, grant;
  logic [19:0]   gen_addr;
  logic          gen_last;
  logic          unused_bits;

  assign cmd_wr    = ctrl_cs && ctrl_wr && (ctrl_addr == REG_CMD);
  assign abort_cmd = cmd_wr && ctrl_wr_data[CMD_ABORT_BIT];
  assign start_cmd = cmd_wr && ctrl_wr_data[CMD_START_BIT];
  assign grant     = eng_adv && !cpu_cs;

`ifdef FILL_CLIP_EN
  logic [10:0] room_w, room_h;

  // Clip the latched rectangle to the frame; an origin off the frame means no pixels.
  always_comb begin
    room_w = 11'(H_MAX - 32'(lat_x0));
    room_h = 11'(V_MAX - 32'(lat_y0));
    clip_w = lat_w;
    clip_h = lat_h;
    if ((32'(lat_x0) >= H_MAX) || (32'(lat_y0) >= V_MAX)) begin
      clip_w = '0;
      clip_h = '0;
    end else begin
      if (lat_w > room_w) clip_w = room_w;
      if (lat_h > room_h) clip_h = room_h;
    end
  end
  assign unused_bits = ^{ctrl_wr_data[31:27], ctrl_wr_data[15:11]};
`else
  assign clip_w      = lat_w;
  assign clip_h      = lat_h;
  assign unused_bits = ^{ctrl_wr_data[31:27], ctrl_wr_data[15:11], 32'(V_MAX)};
`endif

  // Register file: software view, may change freely while a fill runs.
  always_ff @(posedge clk_sys or negedge reset_sys) begin
    if (!reset_sys) begin
      reg_x0     <= '0;
      reg_y0     <= '0;
      reg_w      <= '0;
      reg_h      <= '0;
      reg_colour <= '0;
    end else if (ctrl_cs && ctrl_wr) begin
      case (ctrl_addr)
        REG_ORG: begin
          reg_x0 <= ctrl_wr_data[9:0];
          reg_y0 <= ctrl_wr_data[25:16];
        end
        REG_SIZE: begin
          reg_w <= ctrl_wr_data[10:0];
          reg_h <= ctrl_wr_data[26:16];
        end
        REG_COLOR: reg_colour <= ctrl_wr_data[DW-1:0];
        default: ;
      endcase
    end
  end

  // Register readback, combinational.
  always_comb begin
    ctrl_rd_data = '0;
    case (ctrl_addr)
      REG_ORG:   ctrl_rd_data = {6'b0, reg_y0, 6'b0, reg_x0};
      REG_SIZE:  ctrl_rd_data = {5'b0, reg_h, 5'b0, reg_w};
      REG_COLOR: ctrl_rd_data = 32'(reg_colour);
      default:   ctrl_rd_data = {30'b0, fill_done, fill_busy};
    endcase
  end

  // Snapshot of the rectangle taken when a start is accepted.
  always_ff @(posedge clk_sys or negedge reset_sys) begin
    if (!reset_sys) begin
      lat_x0     <= '0;
      lat_y0     <= '0;
      lat_w      <= '0;
      lat_h      <= '0;
      lat_colour <= '0;
    end else if (start_acc) begin
      lat_x0     <= reg_x0;
      lat_y0     <= reg_y0;
      lat_w      <= reg_w;
      lat_h      <= reg_h;
      lat_colour <= reg_colour;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_sys or negedge reset_sys) begin
    if (!reset_sys) state <= IDLE;
    else            state <= state_nxt;
  end

  // FSM next state and controls; abort overrides everything, including a same-write start.
  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    load      = 1'b0;
    eng_adv   = 1'b0;
    set_done  = 1'b0;
    fill_busy = (state == SETUP) || (state == WRITE);
    if (abort_cmd) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start_cmd) begin
            start_acc = 1'b1;
            state_nxt = SETUP;
          end
        end
        SETUP: begin
          load      = 1'b1;
          state_nxt = ((clip_w == '0) || (clip_h == '0)) ? DONE : WRITE;
        end
        WRITE: begin
          eng_adv = 1'b1;
          if (!cpu_cs && gen_last) state_nxt = DONE;
        end
        default: begin
          set_done  = 1'b1;
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // Sticky completion flag: cleared by an accepted start, set on leaving DONE.
  always_ff @(posedge clk_sys or negedge reset_sys) begin
    if (!reset_sys)     fill_done <= 1'b0;
    else if (start_acc) fill_done <= 1'b0;
    else if (set_done)  fill_done <= 1'b1;
  end

  fill_addr_gen #(
    .H_MAX (H_MAX)
  ) u_addr_gen (
    .clk_sys   (clk_sys),
    .reset_sys (reset_sys),
    .load      (load),
    .advance   (eng_adv),
    .stall     (cpu_cs),
    .x0        (lat_x0),
    .y0        (lat_y0),
    .w         (clip_w),
    .h         (clip_h),
    .addr      (gen_addr),
    .last      (gen_last)
  );

  // Registered video port: CPU first, then the engine; addr/data hold when idle.
  always_ff @(posedge clk_sys or negedge reset_sys) begin
    if (!reset_sys) begin
      video_cs      <= 1'b0;
      video_wr      <= 1'b0;
      video_addr    <= '0;
      video_wr_data <= '0;
    end else if (cpu_cs) begin
      video_cs      <= 1'b1;
      video_wr      <= cpu_wr;
      video_addr    <= cpu_addr;
      video_wr_data <= cpu_wr_data;
    end else if (grant) begin
      video_cs      <= 1'b1;
      video_wr      <= 1'b1;
      video_addr    <= {1'b1, gen_addr};
      video_wr_data <= 32'(lat_colour);
    end else begin
      video_cs      <= 1'b0;
      video_wr      <= 1'b0;
    end
  end

endmodule
